// File: rtl/tlb_pkg.sv
// Shared TLB definitions: op codes, sequencer state encoding and CP0 field positions.
// Also used by the fetch/data address translators.
package tlb_pkg;

    localparam logic [1:0] OP_TLBP  = 2'b00;
    localparam logic [1:0] OP_TLBR  = 2'b01;
    localparam logic [1:0] OP_TLBWI = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PROBE   = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4
    } tlb_state_e;

    localparam int VPN2_HI = 31;
    localparam int VPN2_LO = 13;
    localparam int VPN2_W  = VPN2_HI - VPN2_LO + 1;
    localparam int MASK_HI = 24;
    localparam int MASK_LO = 13;
    localparam int MASK_W  = MASK_HI - MASK_LO + 1;
    localparam int ASID_HI = 7;
    localparam int ASID_LO = 0;
    localparam int G_BIT   = 0;
    localparam int P_BIT   = 31;

endpackage

// File: rtl/tlb_match_cmp.sv
// Combinational match of a virtual page / ASID query against one TLB entry.
// Mask bits widen the page by ignoring the corresponding low VPN2 bits.
module tlb_match_cmp
    import tlb_pkg::*;
(
    input  logic [VPN2_W-1:0]            q_vpn2_i,
    input  logic [ASID_HI-ASID_LO:0]     q_asid_i,
    input  logic [VPN2_W-1:0]            e_vpn2_i,
    input  logic [ASID_HI-ASID_LO:0]     e_asid_i,
    input  logic [MASK_W-1:0]            e_mask_i,
    input  logic                         e_g0_i,
    input  logic                         e_g1_i,
    output logic                         match_o
);

    logic hi_eq_s;
    logic lo_eq_s;
    logic asid_ok_s;

    // Upper VPN2 always compared, lower part only where the page mask is clear
    always_comb begin
        hi_eq_s   = (q_vpn2_i[VPN2_W-1:MASK_W] == e_vpn2_i[VPN2_W-1:MASK_W]);
        lo_eq_s   = (((q_vpn2_i[MASK_W-1:0] ^ e_vpn2_i[MASK_W-1:0]) & ~e_mask_i) == {MASK_W{1'b0}});
        asid_ok_s = (e_g0_i & e_g1_i) | (q_asid_i == e_asid_i);
        match_o   = hi_eq_s & lo_eq_s & asid_ok_s;
    end

endmodule

// File: rtl/tlb_op_seq.sv
// Sequencer for TLBP/TLBR/TLBWI: holds the EXE instruction while it probes,
// reads or writes the single-port TLB entry array and reports back to CP0.
module tlb_op_seq
    import tlb_pkg::*;
#(
    parameter int ENTRY_NUM = 32,
    parameter int IDX_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [1:0]       op_type,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    input  logic [31:0]      index_in,
    input  logic [31:0]      entryhi_in,
    input  logic [31:0]      entrylo0_in,
    input  logic [31:0]      entrylo1_in,
    input  logic [31:0]      pagemask_in,
    output logic [IDX_W-1:0] tlb_raddr,
    input  logic [31:0]      tlb_rd_entryhi,
    input  logic [31:0]      tlb_rd_entrylo0,
    input  logic [31:0]      tlb_rd_entrylo1,
    input  logic [31:0]      tlb_rd_pagemask,
    output logic             tlb_we,
    output logic [IDX_W-1:0] tlb_waddr,
    output logic [31:0]      tlb_wdata_entryhi,
    output logic [31:0]      tlb_wdata_entrylo0,
    output logic [31:0]      tlb_wdata_entrylo1,
    output logic [31:0]      tlb_wdata_pagemask,
    output logic             cp0_tlbp,
    output logic             cp0_tlbr,
    output logic [31:0]      index_t2r,
    output logic [31:0]      entryhi_t2r,
    output logic [31:0]      entrylo0_t2r,
    output logic [31:0]      entrylo1_t2r,
    output logic [31:0]      pagemask_t2r
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRY_NUM - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

    tlb_state_e       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] raddr_q, raddr_d;
    logic [IDX_W-1:0] cmp_idx_q, cmp_idx_d;
    logic             rd_vld_q, rd_vld_d;
    logic [31:0]      entryhi_q, entryhi_d, entrylo0_q, entrylo0_d;
    logic [31:0]      entrylo1_q, entrylo1_d, pagemask_q, pagemask_d;
    logic [31:0]      index_t2r_q, index_t2r_d, entryhi_t2r_q, entryhi_t2r_d;
    logic [31:0]      entrylo0_t2r_q, entrylo0_t2r_d, entrylo1_t2r_q, entrylo1_t2r_d;
    logic [31:0]      pagemask_t2r_q, pagemask_t2r_d;
    logic             match_s;
    logic             unused_idx_s;

    // Index is taken modulo the array size, so the upper bits carry no meaning
    assign unused_idx_s = ^index_in[31:IDX_W];

    tlb_match_cmp u_match (
        .q_vpn2_i (entryhi_q[VPN2_HI:VPN2_LO]),
        .q_asid_i (entryhi_q[ASID_HI:ASID_LO]),
        .e_vpn2_i (tlb_rd_entryhi[VPN2_HI:VPN2_LO]),
        .e_asid_i (tlb_rd_entryhi[ASID_HI:ASID_LO]),
        .e_mask_i (tlb_rd_pagemask[MASK_HI:MASK_LO]),
        .e_g0_i   (tlb_rd_entrylo0[G_BIT]),
        .e_g1_i   (tlb_rd_entrylo1[G_BIT]),
        .match_o  (match_s)
    );

    // Next-state and datapath update
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        idx_d          = idx_q;
        raddr_d        = raddr_q;
        cmp_idx_d      = cmp_idx_q;
        rd_vld_d       = rd_vld_q;
        entryhi_d      = entryhi_q;
        entrylo0_d     = entrylo0_q;
        entrylo1_d     = entrylo1_q;
        pagemask_d     = pagemask_q;
        index_t2r_d    = index_t2r_q;
        entryhi_t2r_d  = entryhi_t2r_q;
        entrylo0_t2r_d = entrylo0_t2r_q;
        entrylo1_t2r_d = entrylo1_t2r_q;
        pagemask_t2r_d = pagemask_t2r_q;

        case (state_q)
            ST_IDLE: begin
                if (op_valid && !flush) begin
                    op_d       = op_type;
                    idx_d      = index_in[IDX_W-1:0];
                    entryhi_d  = entryhi_in;
                    entrylo0_d = entrylo0_in;
                    entrylo1_d = entrylo1_in;
                    pagemask_d = pagemask_in;
                    rd_vld_d   = 1'b0;
                    case (op_type)
                        OP_TLBP: begin
                            state_d = ST_PROBE;
                            raddr_d = {IDX_W{1'b0}};
                        end
                        OP_TLBR: begin
                            state_d = ST_RD_WAIT;
                            raddr_d = index_in[IDX_W-1:0];
                        end
                        OP_TLBWI: state_d = ST_WRITE;
                        default:  state_d = ST_DONE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PROBE: begin
                // Read data lags the address by one cycle; rd_vld_q marks the first valid compare
                cmp_idx_d = raddr_q;
                rd_vld_d  = 1'b1;
                if (raddr_q != LAST_IDX) begin
                    raddr_d = raddr_q + IDX_ONE;
                end else begin
                    raddr_d = raddr_q;
                end
                if (rd_vld_q && match_s) begin
                    state_d                  = ST_DONE;
                    index_t2r_d              = 32'h0000_0000;
                    index_t2r_d[IDX_W-1:0]   = cmp_idx_q;
                end else if (rd_vld_q && (cmp_idx_q == LAST_IDX)) begin
                    state_d            = ST_DONE;
                    index_t2r_d        = 32'h0000_0000;
                    index_t2r_d[P_BIT] = 1'b1;
                end else begin
                    state_d = ST_PROBE;
                end
            end
            ST_RD_WAIT: begin
                if (rd_vld_q) begin
                    state_d        = ST_DONE;
                    entryhi_t2r_d  = tlb_rd_entryhi;
                    entrylo0_t2r_d = tlb_rd_entrylo0;
                    entrylo1_t2r_d = tlb_rd_entrylo1;
                    pagemask_t2r_d = tlb_rd_pagemask;
                end else begin
                    rd_vld_d = 1'b1;
                end
            end
            ST_WRITE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // An aborted op must leave the CP0 result registers untouched
        if (flush && (state_q != ST_IDLE)) begin
            state_d        = ST_IDLE;
            index_t2r_d    = index_t2r_q;
            entryhi_t2r_d  = entryhi_t2r_q;
            entrylo0_t2r_d = entrylo0_t2r_q;
            entrylo1_t2r_d = entrylo1_t2r_q;
            pagemask_t2r_d = pagemask_t2r_q;
        end else begin
            state_d = state_d;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            op_q           <= 2'b00;
            idx_q          <= '0;
            raddr_q        <= '0;
            cmp_idx_q      <= '0;
            rd_vld_q       <= 1'b0;
            entryhi_q      <= 32'h0;
            entrylo0_q     <= 32'h0;
            entrylo1_q     <= 32'h0;
            pagemask_q     <= 32'h0;
            index_t2r_q    <= 32'h0;
            entryhi_t2r_q  <= 32'h0;
            entrylo0_t2r_q <= 32'h0;
            entrylo1_t2r_q <= 32'h0;
            pagemask_t2r_q <= 32'h0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            idx_q          <= idx_d;
            raddr_q        <= raddr_d;
            cmp_idx_q      <= cmp_idx_d;
            rd_vld_q       <= rd_vld_d;
            entryhi_q      <= entryhi_d;
            entrylo0_q     <= entrylo0_d;
            entrylo1_q     <= entrylo1_d;
            pagemask_q     <= pagemask_d;
            index_t2r_q    <= index_t2r_d;
            entryhi_t2r_q  <= entryhi_t2r_d;
            entrylo0_t2r_q <= entrylo0_t2r_d;
            entrylo1_t2r_q <= entrylo1_t2r_d;
            pagemask_t2r_q <= pagemask_t2r_d;
        end
    end

    assign busy               = (state_q != ST_IDLE);
    assign done               = (state_q == ST_DONE) && !flush;
    assign cp0_tlbp           = done && (op_q == OP_TLBP);
    assign cp0_tlbr           = done && (op_q == OP_TLBR);
    assign tlb_we             = (state_q == ST_WRITE) && !flush;
    assign tlb_raddr          = raddr_q;
    assign tlb_waddr          = idx_q;
    assign tlb_wdata_entryhi  = entryhi_q;
    assign tlb_wdata_entrylo0 = entrylo0_q;
    assign tlb_wdata_entrylo1 = entrylo1_q;
    assign tlb_wdata_pagemask = pagemask_q;
    assign index_t2r          = index_t2r_q;
    assign entryhi_t2r        = entryhi_t2r_q;
    assign entrylo0_t2r       = entrylo0_t2r_q;
    assign entrylo1_t2r       = entrylo1_t2r_q;
    assign pagemask_t2r       = pagemask_t2r_q;

endmodule

// File: tb/tb_tlb_op_seq.sv
// Scoreboard bench for tlb_op_seq with a behavioural TLB array (one-cycle read latency).
module tb_tlb_op_seq;

    logic        clk = 1'b0;
    logic        rst, op_valid, flush, busy, done, tlb_we, cp0_tlbp, cp0_tlbr;
    logic [1:0]  op_type;
    logic [31:0] index_in, entryhi_in, entrylo0_in, entrylo1_in, pagemask_in;
    logic [4:0]  tlb_raddr, tlb_waddr;
    logic [31:0] rd_eh, rd_l0, rd_l1, rd_pm;
    logic [31:0] wd_eh, wd_l0, wd_l1, wd_pm;
    logic [31:0] index_t2r, entryhi_t2r, entrylo0_t2r, entrylo1_t2r, pagemask_t2r;

    logic [31:0] mem_eh [32];
    logic [31:0] mem_l0 [32];
    logic [31:0] mem_l1 [32];
    logic [31:0] mem_pm [32];
    logic        preload;

    typedef struct packed {
        logic [31:0] cyc;
        logic        tlbp;
        logic        tlbr;
        logic [31:0] idx, eh, l0, l1, pm;
    } done_t;
    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] addr, eh, l0, l1, pm;
    } wr_t;

    done_t dq[$];
    wr_t   wq[$];
    done_t dcur;
    wr_t   wcur;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc = 0;
    logic [31:0] exp_idx, exp_eh, exp_l0, exp_l1, exp_pm;

    always #5 clk = ~clk;

    tlb_op_seq #(.ENTRY_NUM(32), .IDX_W(5)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_type(op_type), .flush(flush),
        .busy(busy), .done(done),
        .index_in(index_in), .entryhi_in(entryhi_in), .entrylo0_in(entrylo0_in),
        .entrylo1_in(entrylo1_in), .pagemask_in(pagemask_in),
        .tlb_raddr(tlb_raddr),
        .tlb_rd_entryhi(rd_eh), .tlb_rd_entrylo0(rd_l0), .tlb_rd_entrylo1(rd_l1), .tlb_rd_pagemask(rd_pm),
        .tlb_we(tlb_we), .tlb_waddr(tlb_waddr),
        .tlb_wdata_entryhi(wd_eh), .tlb_wdata_entrylo0(wd_l0), .tlb_wdata_entrylo1(wd_l1), .tlb_wdata_pagemask(wd_pm),
        .cp0_tlbp(cp0_tlbp), .cp0_tlbr(cp0_tlbr),
        .index_t2r(index_t2r), .entryhi_t2r(entryhi_t2r), .entrylo0_t2r(entrylo0_t2r),
        .entrylo1_t2r(entrylo1_t2r), .pagemask_t2r(pagemask_t2r)
    );

    // TLB array model: registered read, write on strobe; filler entries never match the probes
    always @(posedge clk) begin
        rd_eh <= mem_eh[tlb_raddr];
        rd_l0 <= mem_l0[tlb_raddr];
        rd_l1 <= mem_l1[tlb_raddr];
        rd_pm <= mem_pm[tlb_raddr];
        if (preload) begin
            for (int i = 0; i < 32; i++) begin
                mem_eh[i] <= 32'h7000_00FF | (i << 13);
                mem_l0[i] <= 32'h0;
                mem_l1[i] <= 32'h0;
                mem_pm[i] <= 32'h0;
            end
        end else if (tlb_we) begin
            mem_eh[tlb_waddr] <= wd_eh;
            mem_l0[tlb_waddr] <= wd_l0;
            mem_l1[tlb_waddr] <= wd_l1;
            mem_pm[tlb_waddr] <= wd_pm;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT signals done or a write
    always @(negedge clk) begin
        if (done) begin
            if (dq.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'h0);
            end else begin
                dcur = dq.pop_front();
                chk("done_cycle", cyc, dcur.cyc);
                chk("cp0_tlbp", 32'(cp0_tlbp), 32'(dcur.tlbp));
                chk("cp0_tlbr", 32'(cp0_tlbr), 32'(dcur.tlbr));
                chk("index_t2r", index_t2r, dcur.idx);
                chk("entryhi_t2r", entryhi_t2r, dcur.eh);
                chk("entrylo0_t2r", entrylo0_t2r, dcur.l0);
                chk("entrylo1_t2r", entrylo1_t2r, dcur.l1);
                chk("pagemask_t2r", pagemask_t2r, dcur.pm);
            end
        end
        if ((cp0_tlbp || cp0_tlbr) && !done) chk("pulse_without_done", 32'(cp0_tlbp | cp0_tlbr), 32'h0);
        if (tlb_we) begin
            if (wq.size() == 0) begin
                chk("unexpected_we", 32'(tlb_we), 32'h0);
            end else begin
                wcur = wq.pop_front();
                chk("we_cycle", cyc, wcur.cyc);
                chk("waddr", 32'(tlb_waddr), wcur.addr);
                chk("wdata_eh", wd_eh, wcur.eh);
                chk("wdata_l0", wd_l0, wcur.l0);
                chk("wdata_l1", wd_l1, wcur.l1);
                chk("wdata_pm", wd_pm, wcur.pm);
            end
        end
    end

    task automatic start();
        @(posedge clk); #1;
        acc = cyc;
    endtask

    task automatic fire(input logic [1:0] op, input logic [31:0] idx, eh, l0, l1, pm);
        op_type = op; index_in = idx; entryhi_in = eh;
        entrylo0_in = l0; entrylo1_in = l1; pagemask_in = pm;
        op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
    endtask

    task automatic push_done(input int lat, input logic p, input logic r);
        dq.push_back('{cyc: 32'(acc + lat), tlbp: p, tlbr: r, idx: exp_idx,
                       eh: exp_eh, l0: exp_l0, l1: exp_l1, pm: exp_pm});
    endtask

    task automatic do_write(input logic [31:0] idx, eh, l0, l1, pm);
        start();
        wq.push_back('{cyc: 32'(acc + 1), addr: idx & 32'h1F, eh: eh, l0: l0, l1: l1, pm: pm});
        push_done(2, 1'b0, 1'b0);
        fire(2'b10, idx, eh, l0, l1, pm);
        wait_idle("tlbwi");
    endtask

    task automatic do_probe(input logic [31:0] eh, input logic [31:0] res, input int lat);
        start();
        exp_idx = res;
        push_done(lat, 1'b1, 1'b0);
        fire(2'b00, 32'h0, eh, 32'h0, 32'h0, 32'h0);
        wait_idle("tlbp");
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) chk({nm, "_timeout"}, 32'(busy), 32'h0);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_busy"}, 32'(busy), 32'h0);
        chk({nm, "_done"}, 32'(done), 32'h0);
        chk({nm, "_we"}, 32'(tlb_we), 32'h0);
        chk({nm, "_raddr"}, 32'(tlb_raddr), 32'h0);
        chk({nm, "_waddr"}, 32'(tlb_waddr), 32'h0);
        chk({nm, "_wdata"}, wd_eh | wd_l0 | wd_l1 | wd_pm, 32'h0);
        chk({nm, "_pulses"}, 32'(cp0_tlbp | cp0_tlbr), 32'h0);
        chk({nm, "_index_t2r"}, index_t2r, 32'h0);
        chk({nm, "_data_t2r"}, entryhi_t2r | entrylo0_t2r | entrylo1_t2r | pagemask_t2r, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; preload = 1'b1; op_valid = 1'b0; flush = 1'b0; op_type = 2'b00;
        index_in = 32'h0; entryhi_in = 32'h0; entrylo0_in = 32'h0; entrylo1_in = 32'h0; pagemask_in = 32'h0;
        exp_idx = 32'h0; exp_eh = 32'h0; exp_l0 = 32'h0; exp_l1 = 32'h0; exp_pm = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; preload = 1'b0;
        check_zero("reset");

        do_write(32'd3, 32'h0040_2005, 32'h0000_1047, 32'h0000_1087, 32'h0);
        do_probe(32'h0040_2005, 32'h0000_0003, 6);
        do_write(32'd3, 32'h0040_2005, 32'h0000_1046, 32'h0000_1086, 32'h0);
        do_probe(32'h0040_2006, 32'h8000_0000, 34);
        do_write(32'd3, 32'h0040_2005, 32'h0000_1047, 32'h0000_1087, 32'h0);
        do_probe(32'h0040_2006, 32'h0000_0003, 6);
        do_write(32'd5, 32'h0060_0005, 32'h0000_2046, 32'h0000_2086, 32'h0000_6000);
        do_probe(32'h0060_6005, 32'h0000_0005, 8);
        do_write(32'd9, 32'h0060_0005, 32'h0000_2046, 32'h0000_2086, 32'h0000_6000);
        do_probe(32'h0060_6005, 32'h0000_0005, 8);

        // TLBR with garbage upper index bits
        start();
        exp_eh = 32'h0040_2005; exp_l0 = 32'h0000_1047; exp_l1 = 32'h0000_1087; exp_pm = 32'h0;
        push_done(3, 1'b0, 1'b1);
        fire(2'b01, 32'hFFFF_FFE3, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("tlbr_raddr", 32'(tlb_raddr), 32'h3);
        wait_idle("tlbr");

        // Reserved op
        start();
        push_done(1, 1'b0, 1'b0);
        fire(2'b11, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        wait_idle("rsvd");

        // Flush in cycle 10 of a missing probe
        start();
        fire(2'b00, 32'h0, 32'h1234_0000, 32'h0, 32'h0, 32'h0);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1; #1;
        chk("flush_probe_done", 32'(done), 32'h0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_probe_idle", 32'(busy), 32'h0);
        chk("flush_probe_index", index_t2r, exp_idx);

        // Flush in the WRITE cycle
        start();
        fire(2'b10, 32'd7, 32'hDEAD_BEEF, 32'h1, 32'h1, 32'h0);
        flush = 1'b1; #1;
        chk("flush_we", 32'(tlb_we), 32'h0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_write_idle", 32'(busy), 32'h0);
        @(posedge clk); #1;
        chk("flush_no_write", mem_eh[7], 32'h7000_E0FF);

        // Reset mid-probe
        start();
        fire(2'b00, 32'h0, 32'h1234_0000, 32'h0, 32'h0, 32'h0);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_zero("rst_mid");
        exp_idx = 32'h0;

        start();
        exp_eh = 32'h0060_0005; exp_l0 = 32'h0000_2046; exp_l1 = 32'h0000_2086; exp_pm = 32'h0000_6000;
        push_done(3, 1'b0, 1'b1);
        fire(2'b01, 32'd9, 32'h0, 32'h0, 32'h0, 32'h0);
        wait_idle("tlbr9");

        repeat (3) @(posedge clk);
        #1;
        chk("done_queue_empty", 32'(dq.size()), 32'h0);
        chk("write_queue_empty", 32'(wq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
